cs_resolver: RTL and testbench
==============================

Name: cs_resolver

Overview:
- Converts a carry-save pair (sum vector s, carry vector c, equal weights) into a single binary value s + c.
- This is the opposite direction of the squeezer/topup reduction stages, which move binary operands into redundant form.
- Sits at the output of the pipelined carry-save modular multiplier. Performs the final carry propagation W bits per cycle, so the full-width adder stays out of the critical path.
- Uses valid/ready handshakes on both sides.

Parameters:
- N, 64, operand width in bits; N must be a multiple of W.
- W, 16, chunk width resolved per cycle; 1 <= W <= N.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  carry-save pair on in_s/in_c is valid
- in_ready  output  1  block can accept a pair
- in_s  input  N  sum vector
- in_c  input  N  carry vector, same bit weights as in_s
- out_valid  output  1  out_sum/out_cout hold a resolved result
- out_ready  input  1  downstream accepts the result
- out_sum  output  N  (in_s + in_c) mod 2^N
- out_cout  output  1  bit N of in_s + in_c

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_n low asynchronously forces: state IDLE, chunk counter 0, carry flop 0, out_sum 0, out_cout 0, out_valid 0.
  - in_ready = 1 while in reset and in IDLE.
- State machine:
  - Three states: IDLE, RUN, DONE. in_ready = (state == IDLE); out_valid = (state == DONE). Both are registered-state decodes with no combinational path from inputs.
  - IDLE, on in_valid && in_ready at an edge: latch in_s and in_c into internal registers, clear carry, clear counter k to 0, go to RUN.
  - RUN, each edge:
    - Compute {cy, r} = s[k*W +: W] + c[k*W +: W] + carry as a (W+1)-bit add.
    - Write r into result chunk k; carry <= cy; k <= k + 1.
    - When k == N/W - 1: out_cout <= cy and go to DONE.
  - DONE: out_sum/out_cout held stable while out_ready is low. On out_ready high at an edge, go to IDLE; out_sum/out_cout keep their last values.
- Timing:
  - Latency: input accepted at edge t gives out_valid high after edge t + N/W.
  - Minimum initiation interval is N/W + 2 cycles. No new input is accepted in RUN or DONE; in_valid there is ignored and the latched operands are unaffected.
  - W == N: RUN lasts exactly one cycle.
- Arithmetic:
  - Unsigned.
  - Chunk carry propagates only through the carry flop, never combinationally across chunks.
  - Result equals the full (N+1)-bit sum for all inputs, including all-ones operands.
- Boundary conditions:
  - Upstream may change in_s/in_c after acceptance without effect.
  - out_ready high while not in DONE has no effect.
  - rst_n asserted mid-RUN or in DONE aborts the operation; the result is lost and out_valid drops immediately (asynchronously).
  - Counter width is clog2(N/W), minimum 1 bit.

Test Plan:
- Reset check: N=64, W=16; hold rst_n low, then release -> in_ready=1, out_valid=0, out_sum=0, out_cout=0. Assert rst_n low 2 cycles into RUN -> out_valid stays 0, in_ready=1 immediately.
- Basic resolve: s=0x0000_0000_0000_0005, c=0x0000_0000_0000_0003, accepted at edge t -> out_valid high after edge t+4, out_sum=0x8, out_cout=0.
- Cross-chunk carry: s=0x0000_0000_0000_FFFF, c=0x1 -> out_sum=0x0000_0000_0001_0000, out_cout=0. Then s=c=0xFFFF_FFFF_FFFF_FFFF -> out_sum=0xFFFF_FFFF_FFFF_FFFE, out_cout=1.
- Backpressure: result ready with out_ready held low 5 cycles -> out_valid and out_sum stable for all 5 cycles. A new in_valid pulse in that window is not accepted (in_ready=0). After out_ready pulse -> IDLE; next pair accepted the following edge.
- Degenerate width: N=W=16, s=0x8000, c=0x8000 -> out_valid 1 cycle after acceptance, out_sum=0x0000, out_cout=1.
- Random regression: 10k random (s, c) pairs with random out_ready stalls at N=64, W=8 -> every result matches the reference (N+1)-bit sum; no result dropped or duplicated.

Source files
------------

// File: rtl/cs_resolver.sv
// Resolves a carry-save pair (s, c) into the binary sum s + c, W bits per cycle.
// The chunk carry only travels through a flop, so no full-width adder is ever built.
module cs_resolver #(
    parameter int unsigned N = 64,
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_s,
    input  logic [N-1:0] in_c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_cout
);

    localparam int unsigned Chunks = N / W;
    localparam int unsigned CntW   = (Chunks > 1) ? $clog2(Chunks) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [N-1:0]      s_q, s_d, c_q, c_d;
    logic [N-1:0]      sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   k_q, k_d;
    logic [W:0]        add;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            s_q     <= '0;
            c_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            carry_q <= carry_d;
            k_q     <= k_d;
        end
    end

    // Operands shift right each RUN cycle, so the active chunk is always in the low W bits.
    assign add = {1'b0, s_q[W-1:0]} + {1'b0, c_q[W-1:0]} + (W+1)'(carry_q);

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        carry_d = carry_q;
        k_d     = k_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    s_d     = in_s;
                    c_d     = in_c;
                    carry_d = 1'b0;
                    k_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                s_d     = s_q >> W;
                c_d     = c_q >> W;
                for (int unsigned j = 0; j < Chunks; j++) begin
                    if (k_q == CntW'(j)) begin
                        sum_d[j*W +: W] = add[W-1:0];
                    end
                end
                carry_d = add[W];
                k_d     = k_q + CntW'(1);
                if (k_q == CntW'(Chunks - 1)) begin
                    cout_d  = add[W];
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_cs_resolver.sv
// Directed bench for cs_resolver: a 64/16 instance for most scenarios and a 16/16
// instance for the single-chunk case.
module tb_cs_resolver;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_cout;
    logic [63:0] a_in_s, a_in_c, a_out_sum;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_cout;
    logic [15:0] b_in_s, b_in_c, b_out_sum;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cs_resolver #(.N(64), .W(16)) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_s      (a_in_s),
        .in_c      (a_in_c),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_sum   (a_out_sum),
        .out_cout  (a_out_cout)
    );

    cs_resolver #(.N(16), .W(16)) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_s      (b_in_s),
        .in_c      (b_in_c),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_sum   (b_out_sum),
        .out_cout  (b_out_cout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction on u_a; returns result and the edge count from acceptance to out_valid.
    task automatic xact_a(input logic [63:0] s, input logic [63:0] c, input int stall,
                          output logic [63:0] sum, output logic cout, output int lat);
        int guard = 0;
        while (!a_in_ready && guard < 50) begin
            tick();
            guard++;
        end
        a_in_s     = s;
        a_in_c     = c;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        a_in_s     = ~s;
        a_in_c     = ~c;
        lat = 0;
        while (!a_out_valid && lat < 50) begin
            tick();
            lat++;
        end
        for (int i = 0; i < stall; i++) tick();
        sum  = a_out_sum;
        cout = a_out_cout;
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_sum !== 64'h0 || a_out_cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: rdy=%b vld=%b sum=%h cout=%b, required rdy=1 vld=0 sum=0 cout=0",
                     a_in_ready, a_out_valid, a_out_sum, a_out_cout);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_released: a rdy=%b vld=%b b rdy=%b vld=%b, required rdy=1 vld=0",
                     a_in_ready, a_out_valid, b_in_ready, b_out_valid);
        end
    endtask

    task automatic test_basic();
        logic [63:0] sum;
        logic        cout;
        int          lat;
        xact_a(64'h5, 64'h3, 0, sum, cout, lat);
        checks++;
        if (sum !== 64'h8) begin
            errors++;
            $display("FAIL basic_sum: got %h, required %h", sum, 64'h8);
        end
        checks++;
        if (cout !== 1'b0) begin
            errors++;
            $display("FAIL basic_cout: got %b, required 0", cout);
        end
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL basic_latency: got %0d, required 4", lat);
        end
    endtask

    task automatic test_cross_chunk();
        logic [63:0] sum;
        logic        cout;
        int          lat;
        xact_a(64'h0000_0000_0000_FFFF, 64'h1, 0, sum, cout, lat);
        checks++;
        if (sum !== 64'h0000_0000_0001_0000 || cout !== 1'b0) begin
            errors++;
            $display("FAIL chunk_carry: got %h/%b, required 0000000000010000/0", sum, cout);
        end
        xact_a(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, sum, cout, lat);
        checks++;
        if (sum !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            errors++;
            $display("FAIL all_ones_sum: got %h, required fffffffffffffffe", sum);
        end
        checks++;
        if (cout !== 1'b1) begin
            errors++;
            $display("FAIL all_ones_cout: got %b, required 1", cout);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_sum = 64'h2222_2222_2222_2211;
        a_in_s     = 64'h1234_5678_9ABC_DEF0;
        a_in_c     = 64'h0FED_CBA9_8765_4321;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        repeat (4) tick();
        // A competing pair is offered while the result waits.
        a_in_s     = 64'hDEAD_BEEF_0000_0001;
        a_in_c     = 64'h1;
        a_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (a_out_valid !== 1'b1 || a_out_sum !== exp_sum || a_out_cout !== 1'b0 || a_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: vld=%b sum=%h cout=%b rdy=%b, required 1/%h/0/0",
                         i, a_out_valid, a_out_sum, a_out_cout, a_in_ready, exp_sum);
            end
            tick();
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_sum !== exp_sum) begin
            errors++;
            $display("FAIL drain_idle: rdy=%b vld=%b sum=%h, required 1/0/%h", a_in_ready, a_out_valid,
                     a_out_sum, exp_sum);
        end
        a_in_s     = 64'h1;
        a_in_c     = 64'h2;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        checks++;
        if (a_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL next_accept: rdy=%b, required 0", a_in_ready);
        end
        repeat (4) tick();
        checks++;
        if (a_out_valid !== 1'b1 || a_out_sum !== 64'h3) begin
            errors++;
            $display("FAIL next_result: vld=%b sum=%h, required 1/3", a_out_valid, a_out_sum);
        end
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        a_in_s     = 64'hFFFF;
        a_in_c     = 64'h1;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0 || a_out_sum !== 64'h0) begin
            errors++;
            $display("FAIL reset_mid_run: rdy=%b vld=%b sum=%h, required 1/0/0", a_in_ready, a_out_valid,
                     a_out_sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) tick();
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_abort: vld=%b rdy=%b, required 0/1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_degenerate();
        int lat = 0;
        b_in_s     = 16'h8000;
        b_in_c     = 16'h8000;
        b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        while (!b_out_valid && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 1 || b_out_sum !== 16'h0000 || b_out_cout !== 1'b1) begin
            errors++;
            $display("FAIL single_chunk: lat=%0d sum=%h cout=%b, required 1/0000/1", lat, b_out_sum,
                     b_out_cout);
        end
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [63:0] s, c, sum;
        logic        cout;
        logic [64:0] ref_sum;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            s = {$urandom(), $urandom()};
            c = {$urandom(), $urandom()};
            if (i % 8 == 0) c = ~s;
            ref_sum = {1'b0, s} + {1'b0, c};
            xact_a(s, c, int'($urandom_range(0, 3)), sum, cout, lat);
            checks++;
            if ({cout, sum} !== ref_sum || lat !== 4) begin
                errors++;
                $display("FAIL random[%0d]: got %b/%h lat=%0d, required %b/%h lat=4",
                         i, cout, sum, lat, ref_sum[64], ref_sum[63:0]);
            end
        end
    endtask

    initial begin
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_s = '0; a_in_c = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_s = '0; b_in_c = '0;
        test_reset();
        test_basic();
        test_cross_chunk();
        test_backpressure();
        test_reset_mid_run();
        test_degenerate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
